// File: rtl/oka_pkg.sv
// Shared constants, FSM state encoding and the bit-spread helper for the
// sequential 24-bit overlap-free Karatsuba multiplier.
package oka_pkg;

   localparam int N  = 24;
   localparam int H  = 12;
   localparam int PW = 47;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EVEN = 3'd1,
      ODD  = 3'd2,
      MID  = 3'd3,
      DONE = 3'd4
   } state_t;

   // spread(p) places p[k] at bit 2k, i.e. substitutes x -> x^2.
   function automatic logic [44:0] spread(input logic [22:0] p);
      logic [44:0] r;
      r = '0;
      for (int k = 0; k < 23; k++) begin
         r[2*k] = p[k];
      end
      return r;
   endfunction

endpackage

// File: rtl/OKA_12bit.sv
// Combinational 12x12 -> 23-bit carry-less multiplier, built as one level of
// overlap-free (even/odd) Karatsuba over three 6x6 schoolbook products.
module OKA_12bit
   import oka_pkg::*;
(
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   output logic [2*H-2:0] y
);

   localparam int Q = H / 2;

   function automatic logic [2*Q-2:0] clmul6(input logic [Q-1:0] x, input logic [Q-1:0] z);
      logic [2*Q-2:0] r;
      r = '0;
      for (int i = 0; i < Q; i++) begin
         if (z[i]) r = r ^ ({{(Q-1){1'b0}}, x} << i);
      end
      return r;
   endfunction

   function automatic logic [4*Q-3:0] spread11(input logic [2*Q-2:0] p);
      logic [4*Q-3:0] r;
      r = '0;
      for (int k = 0; k < 2*Q-1; k++) begin
         r[2*k] = p[k];
      end
      return r;
   endfunction

   logic [Q-1:0]   ae, ao, be, bo;
   logic [2*Q-2:0] pe, po, pm;

   always_comb begin
      ae = '0;
      ao = '0;
      be = '0;
      bo = '0;
      for (int i = 0; i < Q; i++) begin
         ae[i] = a[2*i];
         ao[i] = a[2*i+1];
         be[i] = b[2*i];
         bo[i] = b[2*i+1];
      end
   end

   assign pe = clmul6(ae, be);
   assign po = clmul6(ao, bo);
   assign pm = clmul6(ae ^ ao, be ^ bo);

   // Cross term ae*bo ^ ao*be recovered as pm ^ pe ^ po, then recombined.
   assign y = {2'b00, spread11(pe)}
            ^ {1'b0, spread11(pm ^ pe ^ po), 1'b0}
            ^ {spread11(po), 2'b00};

endmodule

// File: rtl/oka_24bit_seq_ctrl.sv
// Sequential 24-bit GF(2) multiplier: one shared OKA_12bit core computes the
// three Karatsuba sub-products over EVEN/ODD/MID. Optional done_cnt via OKA_SEQ_CNT_EN.
module oka_24bit_seq_ctrl
   import oka_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] y
`ifdef OKA_SEQ_CNT_EN
   ,
   output logic [15:0]   done_cnt
`endif
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid/ready levels are evaluated on that same edge.

   state_t state, nxt;

   logic [N-1:0]   a_r, b_r;
   logic [H-1:0]   ae, ao, be, bo;
   logic [H-1:0]   core_a, core_b;
   logic [2*H-2:0] core_y;
   logic [2*H-2:0] pe, po;

   always_comb begin
      ae = '0;
      ao = '0;
      be = '0;
      bo = '0;
      for (int i = 0; i < H; i++) begin
         ae[i] = a_r[2*i];
         ao[i] = a_r[2*i+1];
         be[i] = b_r[2*i];
         bo[i] = b_r[2*i+1];
      end
   end

   OKA_12bit u_core (
      .a (core_a),
      .b (core_b),
      .y (core_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = in_valid ? EVEN : IDLE;
         EVEN:    nxt = ODD;
         ODD:     nxt = MID;
         MID:     nxt = DONE;
         DONE:    nxt = out_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      core_a    = '0;
      core_b    = '0;
      case (state)
         EVEN: begin
            core_a = ae;
            core_b = be;
         end
         ODD: begin
            core_a = ao;
            core_b = bo;
         end
         MID: begin
            core_a = ae ^ ao;
            core_b = be ^ bo;
         end
         default: begin
            core_a = '0;
            core_b = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= '0;
         b_r <= '0;
         pe  <= '0;
         po  <= '0;
         y   <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            a_r <= a;
            b_r <= b;
         end
         if (state == EVEN) pe <= core_y;
         if (state == ODD)  po <= core_y;
         // core_y holds pm during MID; the full product is assembled here.
         if (state == MID) begin
            y <= {2'b00, spread(pe)}
               ^ {1'b0, spread(pe ^ po ^ core_y), 1'b0}
               ^ {spread(po), 2'b00};
         end
      end
   end

`ifdef OKA_SEQ_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            done_cnt <= '0;
      else if (state == DONE && out_ready) done_cnt <= done_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_oka_24bit_seq_ctrl.sv
// Self-checking bench for oka_24bit_seq_ctrl: directed operands, a plain
// carry-less multiply model, per-cycle output compare. Honours OKA_SEQ_CNT_EN.
module tb_oka_24bit_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] a;
   logic [23:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [46:0] y;
`ifdef OKA_SEQ_CNT_EN
   logic [15:0] done_cnt;
`endif

   always #5 clk = ~clk;

   oka_24bit_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
`ifdef OKA_SEQ_CNT_EN
      ,
      .done_cnt  (done_cnt)
`endif
   );

   int          checks   = 0;
   int          passed   = 0;
   int          hs_count = 0;
   logic [46:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: textbook shift-and-xor polynomial product over GF(2).
   function automatic logic [46:0] clmul(input logic [23:0] x, input logic [23:0] z);
      logic [46:0] r;
      r = '0;
      for (int i = 0; i < 24; i++) begin
         if (z[i]) r = r ^ ({23'd0, x} << i);
      end
      return r;
   endfunction

   // Compare process: whenever a product is presented it must match the model.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid) begin
            chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
            if (exp_q.size() == 0) chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
            else                   chk("y_vs_model", {17'd0, y}, {17'd0, exp_q[0]});
         end
      end
   end

   task automatic do_op(input logic [23:0] av, input logic [23:0] bv, input int hold,
                        input bit has_lit, input logic [46:0] lit);
      logic [46:0] m;
      logic [46:0] y0;
      int          n;
      bit          seen;
      m = clmul(av, bv);
      if (has_lit) chk("model_pin", {17'd0, m}, {17'd0, lit});
      @(negedge clk);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      exp_q.push_back(m);
      #1;
      in_valid = 1'b0;
      a        = 24'($urandom);
      b        = 24'($urandom);
      n    = 1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk("latency", 64'(n), 64'd4);
      if (seen) begin
         y0       = y;
         in_valid = 1'b1;
         repeat (hold) begin
            @(posedge clk);
            #1;
            chk("bp_y_stable", {17'd0, y}, {17'd0, y0});
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         end
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         in_valid  = 1'b0;
         void'(exp_q.pop_front());
         hs_count++;
         chk("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
         chk("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef OKA_SEQ_CNT_EN
         chk("done_cnt", {48'd0, done_cnt}, 64'(hs_count));
`endif
      end else begin
         exp_q.delete();
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #3;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_y", {17'd0, y}, 64'd0);
`ifdef OKA_SEQ_CNT_EN
      chk("rst_done_cnt", {48'd0, done_cnt}, 64'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      do_op(24'h000001, 24'h000001, 0, 1'b1, 47'h1);
      do_op(24'h000003, 24'h000003, 0, 1'b1, 47'h5);
      do_op(24'hFFFFFF, 24'h000001, 0, 1'b1, 47'h000000FFFFFF);
      do_op(24'h800000, 24'h800000, 0, 1'b1, 47'h400000000000);
      do_op(24'h000007, 24'h000005, 0, 1'b1, 47'h1B);
      do_op(24'hA5A5A5, 24'h5A5A5A, 10, 1'b0, 47'h0);

      // Abort: accept, let it reach ODD, then pulse reset.
      @(negedge clk);
      a        = 24'h123456;
      b        = 24'h654321;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_y", {17'd0, y}, 64'd0);
      hs_count = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         chk("abort_no_out_valid", {63'd0, out_valid}, 64'd0);
      end
`ifdef OKA_SEQ_CNT_EN
      chk("abort_done_cnt", {48'd0, done_cnt}, 64'd0);
`endif

      do_op(24'h000002, 24'h000002, 0, 1'b1, 47'h4);
      do_op(24'hFFFFFF, 24'hFFFFFF, 2, 1'b1, 47'h555555555555);
      do_op(24'h0F0F0F, 24'hC3C3C3, 0, 1'b0, 47'h0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
